// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: fetch-side types shared by the fetch-result formatter, the fetch queue and decode.
package fetch_queue_pkg;

    localparam int INST_W    = 32;
    localparam int PC_W      = 64;
    localparam int BR_TYPE_W = 4;

    typedef struct packed {
        logic [PC_W-1:0]      pc;
        logic [INST_W-1:0]    inst;
        logic                 bp_valid;
        logic                 bp_taken;
        logic [PC_W-1:0]      bp_target;
        logic [BR_TYPE_W-1:0] bp_type;
    } fq_entry_t;

    // Prediction fields are only kept for the slot that owns the predicted branch.
    function automatic fq_entry_t make_entry(
        input logic [PC_W-1:0]      pc,
        input logic [INST_W-1:0]    inst,
        input logic                 hit,
        input logic                 taken,
        input logic [PC_W-1:0]      target,
        input logic [BR_TYPE_W-1:0] br_type
    );
        fq_entry_t e;
        e.pc        = pc;
        e.inst      = inst;
        e.bp_valid  = hit;
        e.bp_taken  = hit & taken;
        e.bp_target = hit ? target : '0;
        e.bp_type   = hit ? br_type : '0;
        return e;
    endfunction

endpackage

// File: rtl/fetch_queue_compact.sv
// fetch_queue_compact: squeezes the valid slots of a 2-wide fetch pack into consecutive queue entries.
module fetch_queue_compact
    import fetch_queue_pkg::*;
(
    input  logic                 enq,
    input  logic                 valid_0,
    input  logic                 valid_1,
    input  logic [PC_W-1:0]      pc,
    input  logic [INST_W-1:0]    inst_0,
    input  logic [INST_W-1:0]    inst_1,
    input  logic                 bp_valid,
    input  logic [PC_W-1:0]      bp_target,
    input  logic [BR_TYPE_W-1:0] bp_type,
    input  logic                 bp_select,
    input  logic                 bp_taken,
    output fq_entry_t            ent_0,
    output fq_entry_t            ent_1,
    output logic                 we_0,
    output logic                 we_1,
    output logic                 off_1,
    output logic [1:0]           n_enq
);

    always_comb begin
        we_0  = enq & valid_0;
        we_1  = enq & valid_1;
        off_1 = we_0;
        n_enq = {1'b0, we_0} + {1'b0, we_1};
        ent_0 = make_entry(pc, inst_0, bp_valid & ~bp_select, bp_taken, bp_target, bp_type);
        ent_1 = make_entry(pc + PC_W'(4), inst_1, bp_valid & bp_select, bp_taken, bp_target, bp_type);
    end

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: circular instruction buffer between fetch-pack formatting and decode,
// presenting the two oldest entries per cycle with all-or-nothing dequeue.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 io_i_flush,
    input  logic                 io_i_fetch_pack_valid,
    input  logic                 io_i_fetch_pack_bits_valids_0,
    input  logic                 io_i_fetch_pack_bits_valids_1,
    input  logic [PC_W-1:0]      io_i_fetch_pack_bits_pc,
    input  logic [INST_W-1:0]    io_i_fetch_pack_bits_insts_0,
    input  logic [INST_W-1:0]    io_i_fetch_pack_bits_insts_1,
    input  logic                 io_i_fetch_pack_bits_branch_predict_pack_valid,
    input  logic [PC_W-1:0]      io_i_fetch_pack_bits_branch_predict_pack_target,
    input  logic [BR_TYPE_W-1:0] io_i_fetch_pack_bits_branch_predict_pack_branch_type,
    input  logic                 io_i_fetch_pack_bits_branch_predict_pack_select,
    input  logic                 io_i_fetch_pack_bits_branch_predict_pack_taken,
    output logic                 io_o_stall,
    input  logic                 io_i_decode_ready,
    output logic                 io_o_decode_valids_0,
    output logic                 io_o_decode_valids_1,
    output logic [PC_W-1:0]      io_o_decode_pcs_0,
    output logic [PC_W-1:0]      io_o_decode_pcs_1,
    output logic [INST_W-1:0]    io_o_decode_insts_0,
    output logic [INST_W-1:0]    io_o_decode_insts_1,
    output logic                 io_o_decode_bp_valid_0,
    output logic                 io_o_decode_bp_valid_1,
    output logic                 io_o_decode_bp_taken_0,
    output logic                 io_o_decode_bp_taken_1,
    output logic [PC_W-1:0]      io_o_decode_bp_target_0,
    output logic [PC_W-1:0]      io_o_decode_bp_target_1,
    output logic [BR_TYPE_W-1:0] io_o_decode_bp_type_0,
    output logic [BR_TYPE_W-1:0] io_o_decode_bp_type_1
);

    localparam int PTR_W = $clog2(DEPTH);
    // A full pack needs two free slots, so stall once fewer than two remain.
    localparam logic [PTR_W:0] STALL_AT = (PTR_W+1)'(DEPTH - 1);

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    fq_entry_t        mem_q [DEPTH];
    fq_entry_t        ent_0, ent_1, lane_0, lane_1;
    logic             enq, we_0, we_1, off_1, valid_0, valid_1;
    logic [1:0]       n_enq, n_deq;
    logic [PTR_W-1:0] widx_1, ridx_1;

    assign io_o_stall = count_q >= STALL_AT;
    assign enq        = io_i_fetch_pack_valid & ~io_o_stall & ~io_i_flush;

    fetch_queue_compact u_compact (
        .enq       (enq),
        .valid_0   (io_i_fetch_pack_bits_valids_0),
        .valid_1   (io_i_fetch_pack_bits_valids_1),
        .pc        (io_i_fetch_pack_bits_pc),
        .inst_0    (io_i_fetch_pack_bits_insts_0),
        .inst_1    (io_i_fetch_pack_bits_insts_1),
        .bp_valid  (io_i_fetch_pack_bits_branch_predict_pack_valid),
        .bp_target (io_i_fetch_pack_bits_branch_predict_pack_target),
        .bp_type   (io_i_fetch_pack_bits_branch_predict_pack_branch_type),
        .bp_select (io_i_fetch_pack_bits_branch_predict_pack_select),
        .bp_taken  (io_i_fetch_pack_bits_branch_predict_pack_taken),
        .ent_0     (ent_0),
        .ent_1     (ent_1),
        .we_0      (we_0),
        .we_1      (we_1),
        .off_1     (off_1),
        .n_enq     (n_enq)
    );

    always_comb begin
        valid_0 = (count_q != '0) & ~io_i_flush;
        valid_1 = (count_q > (PTR_W+1)'(1)) & ~io_i_flush;
        ridx_1  = head_q + PTR_W'(1);
        widx_1  = tail_q + PTR_W'(off_1);
        lane_0  = valid_0 ? mem_q[head_q] : '0;
        lane_1  = valid_1 ? mem_q[ridx_1] : '0;
        n_deq   = io_i_decode_ready & ~io_i_flush ? {1'b0, valid_0} + {1'b0, valid_1} : 2'd0;
        head_d  = io_i_flush ? '0 : head_q + PTR_W'(n_deq);
        tail_d  = io_i_flush ? '0 : tail_q + PTR_W'(n_enq);
        count_d = io_i_flush ? '0 : count_q + (PTR_W+1)'(n_enq) - (PTR_W+1)'(n_deq);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (we_0) mem_q[tail_q] <= ent_0;
        if (we_1) mem_q[widx_1] <= ent_1;
    end

    assign io_o_decode_valids_0    = valid_0;
    assign io_o_decode_valids_1    = valid_1;
    assign io_o_decode_pcs_0       = lane_0.pc;
    assign io_o_decode_pcs_1       = lane_1.pc;
    assign io_o_decode_insts_0     = lane_0.inst;
    assign io_o_decode_insts_1     = lane_1.inst;
    assign io_o_decode_bp_valid_0  = lane_0.bp_valid;
    assign io_o_decode_bp_valid_1  = lane_1.bp_valid;
    assign io_o_decode_bp_taken_0  = lane_0.bp_taken;
    assign io_o_decode_bp_taken_1  = lane_1.bp_taken;
    assign io_o_decode_bp_target_0 = lane_0.bp_target;
    assign io_o_decode_bp_target_1 = lane_1.bp_target;
    assign io_o_decode_bp_type_0   = lane_0.bp_type;
    assign io_o_decode_bp_type_1   = lane_1.bp_type;

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed vector table, corner-case sequences and random traffic against a queue model.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    typedef struct {
        logic        rst, flush, pv, v0, v1;
        logic [63:0] pc;
        logic [31:0] i0, i1;
        logic        bpv, sel, taken;
        logic [63:0] tgt;
        logic [3:0]  btype;
        logic        ready;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic        e_stall, e_v0, e_v1;
        logic [63:0] e_pc0;
        logic [31:0] e_inst0;
        logic        e_bpv0;
        logic [63:0] e_tgt0;
    } vec_t;

    logic        clk = 0, rst = 1, flush = 0, pv = 0, v0 = 0, v1 = 0, bpv = 0, sel = 0, taken = 0, ready = 0;
    logic [63:0] pc = 0, tgt = 0;
    logic [31:0] i0 = 0, i1 = 0;
    logic [3:0]  btype = 0;
    logic        stall, ov0, ov1, bpv0, bpv1, tk0, tk1;
    logic [63:0] pc0, pc1, tg0, tg1;
    logic [31:0] in0, in1;
    logic [3:0]  ty0, ty1;
    fq_entry_t   dut_l0, dut_l1;
    fq_entry_t   q[$];
    int          n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    fetch_queue dut (
        .clock(clk), .reset(rst), .io_i_flush(flush),
        .io_i_fetch_pack_valid(pv),
        .io_i_fetch_pack_bits_valids_0(v0), .io_i_fetch_pack_bits_valids_1(v1),
        .io_i_fetch_pack_bits_pc(pc),
        .io_i_fetch_pack_bits_insts_0(i0), .io_i_fetch_pack_bits_insts_1(i1),
        .io_i_fetch_pack_bits_branch_predict_pack_valid(bpv),
        .io_i_fetch_pack_bits_branch_predict_pack_target(tgt),
        .io_i_fetch_pack_bits_branch_predict_pack_branch_type(btype),
        .io_i_fetch_pack_bits_branch_predict_pack_select(sel),
        .io_i_fetch_pack_bits_branch_predict_pack_taken(taken),
        .io_o_stall(stall), .io_i_decode_ready(ready),
        .io_o_decode_valids_0(ov0), .io_o_decode_valids_1(ov1),
        .io_o_decode_pcs_0(pc0), .io_o_decode_pcs_1(pc1),
        .io_o_decode_insts_0(in0), .io_o_decode_insts_1(in1),
        .io_o_decode_bp_valid_0(bpv0), .io_o_decode_bp_valid_1(bpv1),
        .io_o_decode_bp_taken_0(tk0), .io_o_decode_bp_taken_1(tk1),
        .io_o_decode_bp_target_0(tg0), .io_o_decode_bp_target_1(tg1),
        .io_o_decode_bp_type_0(ty0), .io_o_decode_bp_type_1(ty1)
    );

    assign dut_l0 = {pc0, in0, bpv0, tk0, tg0, ty0};
    assign dut_l1 = {pc1, in1, bpv1, tk1, tg1, ty1};

    task automatic chk(input string nm, input logic [199:0] got, input logic [199:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
        end
    endtask

    function automatic stim_t mk_s(input logic fl, input logic p, input logic a, input logic b,
                                   input logic [63:0] pcv, input logic [31:0] x0, input logic [31:0] x1,
                                   input logic bv, input logic sl, input logic tk, input logic [63:0] tg,
                                   input logic rd);
        stim_t s;
        s.rst = 0; s.flush = fl; s.pv = p; s.v0 = a; s.v1 = b; s.pc = pcv; s.i0 = x0; s.i1 = x1;
        s.bpv = bv; s.sel = sl; s.taken = tk; s.tgt = tg; s.btype = bv ? 4'h5 : 4'h0; s.ready = rd;
        return s;
    endfunction

    function automatic stim_t pack2(input logic [63:0] pcv, input logic rd);
        return mk_s(0, 1, 1, 1, pcv, pcv[31:0] ^ 32'h13, pcv[31:0] ^ 32'h93, 0, 0, 0, 0, rd);
    endfunction

    function automatic stim_t idle(input logic rd);
        return mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rd);
    endfunction

    // Expected entry for slot i of a pack, straight from the enqueue rules.
    function automatic fq_entry_t mk_ent(input stim_t s, input int i);
        fq_entry_t e;
        logic hit;
        hit = s.bpv && (int'(s.sel) == i);
        e.pc = s.pc + 64'(4 * i);
        e.inst = (i == 0) ? s.i0 : s.i1;
        e.bp_valid = hit;
        e.bp_taken = hit && s.taken;
        e.bp_target = hit ? s.tgt : '0;
        e.bp_type = hit ? s.btype : '0;
        return e;
    endfunction

    task automatic apply(input stim_t s);
        rst = s.rst; flush = s.flush; pv = s.pv; v0 = s.v0; v1 = s.v1; pc = s.pc;
        i0 = s.i0; i1 = s.i1; bpv = s.bpv; sel = s.sel; taken = s.taken; tgt = s.tgt;
        btype = s.btype; ready = s.ready;
        #1;
    endtask

    task automatic finish_cycle(input stim_t s);
        int n, nd;
        logic es, e0, e1;
        fq_entry_t l0, l1;
        n = q.size();
        es = (16 - n) < 2;
        e0 = n >= 1 && !s.flush;
        e1 = n >= 2 && !s.flush;
        l0 = e0 ? q[0] : '0;
        l1 = e1 ? q[1] : '0;
        chk("model_stall", stall, es);
        chk("model_valids", {ov0, ov1}, {e0, e1});
        chk("model_lane0", dut_l0, l0);
        chk("model_lane1", dut_l1, l1);
        @(posedge clk); #1;
        if (s.rst || s.flush) q.delete();
        else begin
            nd = s.ready ? int'(e0) + int'(e1) : 0;
            repeat (nd) void'(q.pop_front());
            if (s.pv && !es) begin
                if (s.v0) q.push_back(mk_ent(s, 0));
                if (s.v1) q.push_back(mk_ent(s, 1));
            end
        end
    endtask

    task automatic do_cycle(input stim_t s);
        apply(s);
        finish_cycle(s);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t  tv[10];
        stim_t s;
        tv[0] = '{pack2(64'h8000_0000, 1), 0, 0, 0, 64'h0, 32'h0, 0, 64'h0};
        tv[0].s.i0 = 32'h13; tv[0].s.i1 = 32'h93;
        tv[1] = '{idle(1), 0, 1, 1, 64'h8000_0000, 32'h13, 0, 64'h0};
        tv[2] = '{mk_s(0, 1, 0, 1, 64'h1000, 32'haaaa, 32'h1111_0033, 0, 0, 0, 0, 0), 0, 0, 0, 64'h0, 32'h0, 0, 64'h0};
        tv[3] = '{idle(0), 0, 1, 0, 64'h1004, 32'h1111_0033, 0, 64'h0};
        tv[4] = '{mk_s(0, 1, 1, 0, 64'h3000, 32'h6f, 32'h13, 1, 0, 1, 64'h2000, 1), 0, 1, 0, 64'h1004, 32'h1111_0033, 0, 64'h0};
        tv[5] = '{idle(0), 0, 1, 0, 64'h3000, 32'h6f, 1, 64'h2000};
        tv[6] = '{pack2(64'h4000, 0), 0, 1, 0, 64'h3000, 32'h6f, 1, 64'h2000};
        tv[7] = '{pack2(64'h4008, 0), 0, 1, 1, 64'h3000, 32'h6f, 1, 64'h2000};
        tv[8] = '{mk_s(1, 1, 1, 1, 64'h5000, 32'h1, 32'h2, 0, 0, 0, 0, 1), 0, 0, 0, 64'h0, 32'h0, 0, 64'h0};
        tv[9] = '{idle(1), 0, 0, 0, 64'h0, 32'h0, 0, 64'h0};

        apply(idle(0));
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        s = idle(0);
        apply(s);
        chk("reset_stall", stall, 0);
        chk("reset_valids", {ov0, ov1}, 2'b00);
        finish_cycle(s);

        foreach (tv[k]) begin
            apply(tv[k].s);
            chk($sformatf("vec%0d_stall", k), stall, tv[k].e_stall);
            chk($sformatf("vec%0d_valids", k), {ov0, ov1}, {tv[k].e_v0, tv[k].e_v1});
            chk($sformatf("vec%0d_pc0", k), pc0, tv[k].e_pc0);
            chk($sformatf("vec%0d_inst0", k), in0, tv[k].e_inst0);
            chk($sformatf("vec%0d_bpv0", k), bpv0, tv[k].e_bpv0);
            chk($sformatf("vec%0d_tgt0", k), tg0, tv[k].e_tgt0);
            finish_cycle(tv[k].s);
        end

        // Fill to DEPTH-2, then run simultaneous 2-in/2-out cycles across the pointer wrap.
        for (int k = 0; k < 7; k++) do_cycle(pack2(64'h9000_0000 + 64'(8 * k), 0));
        for (int k = 0; k < 3; k++) begin
            s = pack2(64'ha000_0000 + 64'(8 * k), 1);
            apply(s);
            chk("enqdeq_at_14_stall", stall, 0);
            chk("enqdeq_at_14_valids", {ov0, ov1}, 2'b11);
            finish_cycle(s);
        end
        do_cycle(pack2(64'hb000_0000, 0));
        s = pack2(64'hc000_0000, 0);
        apply(s);
        chk("full_stall", stall, 1);
        finish_cycle(s);
        for (int k = 0; k < 9; k++) do_cycle(idle(1));
        s = idle(0);
        apply(s);
        chk("drained_stall", stall, 0);
        chk("drained_valids", {ov0, ov1}, 2'b00);
        finish_cycle(s);

        for (int k = 0; k < 800; k++) begin
            s = mk_s($urandom_range(29) == 0, $urandom_range(3) != 0, 1'($urandom), 1'($urandom),
                     {$urandom, $urandom} & ~64'h7, $urandom, $urandom, 1'($urandom), 1'($urandom),
                     1'($urandom), {$urandom, $urandom}, $urandom_range(2) != 0);
            s.btype = 4'($urandom);
            s.rst = $urandom_range(99) == 0;
            do_cycle(s);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Consumer end of the fetch-pack interface: sits between fetch-result formatting and decode.
- Buffers per-instruction entries from 2-wide fetch packs. Each entry holds the instruction, its PC and its branch-prediction info.
- Presents up to 2 oldest instructions per cycle to decode with a ready handshake.
- Back-pressures fetch via a stall output; supports a pipeline flush.

Parameters:
DEPTH, 16, number of instruction entries; power of 2, >= 4
PTR_W, log2(DEPTH), pointer width; derived, not overridable

Ports:
clock  in  1  system clock
reset  in  1  synchronous active-high reset
io_i_flush  in  1  discard all buffered entries and the current enqueue
io_i_fetch_pack_valid  in  1  fetch pack present
io_i_fetch_pack_bits_valids_0  in  1  slot 0 valid
io_i_fetch_pack_bits_valids_1  in  1  slot 1 valid
io_i_fetch_pack_bits_pc  in  64  8-byte-aligned pack PC
io_i_fetch_pack_bits_insts_0  in  32  slot 0 instruction
io_i_fetch_pack_bits_insts_1  in  32  slot 1 instruction
io_i_fetch_pack_bits_branch_predict_pack_valid  in  1  prediction present
io_i_fetch_pack_bits_branch_predict_pack_target  in  64  predicted target
io_i_fetch_pack_bits_branch_predict_pack_branch_type  in  4  branch type
io_i_fetch_pack_bits_branch_predict_pack_select  in  1  slot holding the predicted branch (0/1)
io_i_fetch_pack_bits_branch_predict_pack_taken  in  1  predicted taken
io_o_stall  out  1  queue cannot accept a pack this cycle
io_i_decode_ready  in  1  decode accepts the presented pair
io_o_decode_valids_0, io_o_decode_valids_1  out  1 each  lane valid
io_o_decode_pcs_0, io_o_decode_pcs_1  out  64 each  instruction PC
io_o_decode_insts_0, io_o_decode_insts_1  out  32 each  instruction
io_o_decode_bp_valid_0/1  out  1 each  this instruction carries a prediction
io_o_decode_bp_taken_0/1  out  1 each  predicted taken
io_o_decode_bp_target_0/1  out  64 each  predicted target
io_o_decode_bp_type_0/1  out  4 each  branch type

Behaviour:
- State: head, tail (PTR_W), count (PTR_W+1), entry array of DEPTH registers.
- Reset (synchronous, active-high): head = tail = count = 0; entry contents don't-care.
  - Outputs after reset: valids = 0, io_o_stall = 0.
- io_o_stall = (DEPTH - count) < 2. Combinational from registered count; independent of dequeue in the same cycle.
- enq = io_i_fetch_pack_valid & ~io_o_stall & ~io_i_flush.
- Compaction (per pack):
  - Slot i is enqueued iff enq & valids_i.
  - Slot 0 is written at tail. Slot 1 is written at tail+1 if slot 0 was also enqueued, else at tail.
  - Entry PC = pack pc + 4*i.
  - tail += n_enq (0/1/2), modulo DEPTH.
- Branch info:
  - Entry bp_valid = predict_valid & (select == i).
  - taken, target and type are copied into the entry only when bp_valid; otherwise stored as 0.
- Decode outputs (combinational from the array):
  - lane 0 = entry[head], lane 1 = entry[head+1 mod DEPTH].
  - valids_0 = count >= 1 & ~io_i_flush; valids_1 = count >= 2 & ~io_i_flush.
  - Invalid lanes drive 0 on all data fields.
- Dequeue:
  - If io_i_decode_ready & ~io_i_flush, n_deq = valids_0 + valids_1.
  - head += n_deq, modulo DEPTH. All-or-nothing per cycle.
- Simultaneous enqueue and dequeue: count_next = count + n_enq - n_deq. Both permitted on the same cycle, including at count = DEPTH-2.
- Flush:
  - Next cycle head = tail = count = 0.
  - Same-cycle enqueue and dequeue are suppressed.
  - Flush has priority over everything except reset.
- Reset asserted mid-operation: identical to a flush plus a pointer clear; in-flight data is lost.
- Pointer wrap: both pointers wrap naturally at DEPTH. Lane 1 read index wraps as well.
- Pack with valids = 00 while enq is asserted: no state change.
- Latency: a PC enqueued in cycle N is visible on the decode lanes in cycle N+1 at the earliest.

Decomposition:
- Shared package (fetch types):
  - Constants: INST_W = 32, PC_W = 64, BR_TYPE_W = 4.
  - Typedef fq_entry_t = {pc, inst, bp_valid, bp_taken, bp_target, bp_type}.
  - The same package is used by the fetch-result formatter and by decode.
- Sub-module fetch_queue_compact:
  - Combinational 2-lane compaction.
  - Inputs: pack + enq. Outputs: two fq_entry_t, per-lane write enables and write offsets, n_enq.
  - The top level keeps the pointers, the array and the dequeue logic.

Test Plan:
- Reset, then pack pc=0x8000_0000, valids=11, insts=0x13/0x93, ready=1 -> next cycle valids=11, pcs 0x8000_0000/0x8000_0004; following cycle valids=00.
- Pack pc=0x1000, valids=01 -> only lane 0 is valid, pc=0x1004, inst = insts_1; count=1.
- Prediction with valid=1, select=0, taken=1, target=0x2000 on pack valids=10 -> lane 0 bp_valid=1, target=0x2000; no second entry.
- Hold ready=0 and push 8 full packs with DEPTH=16 -> stall asserts once count=15 or 16. After that the queue drains in order via ready=1, with the wrap of head and tail checked.
- Count=DEPTH-2 with simultaneous enq 2 and deq 2 -> count stays 14, no stall glitch, FIFO order preserved.
- Flush at count=5 alongside an incoming pack -> next cycle count=0, valids=00, stall=0, and the flush-cycle pack is dropped.
